// File: rtl/rng_pkg.sv
// rng_pkg: constants, FSM states and range-mask helper shared by
// the round-robin LFSR random source.
package rng_pkg;

    localparam logic [15:0] RNG_DEFAULT_SEED = 16'hACE1;
    // Feedback taps: bits 0, 2, 3 and 5 of the shift register.
    localparam logic [15:0] RNG_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        RESP = 2'd2
    } rng_state_t;

    // Smallest 2^k-1 covering limit-1; limit 0 selects the full range.
    function automatic logic [15:0] mask_for_limit(input logic [15:0] limit);
        logic [15:0] m;
        if (limit == 16'd0) begin
            m = 16'hFFFF;
        end else begin
            m = limit - 16'd1;
            m = m | (m >> 1);
            m = m | (m >> 2);
            m = m | (m >> 4);
            m = m | (m >> 8);
        end
        return m;
    endfunction

endpackage

// File: rtl/rng_lfsr16.sv
// rng_lfsr16: 16-bit Fibonacci LFSR with synchronous load and step;
// a zero seed is replaced by the default seed to avoid lock-up.
module rng_lfsr16
    import rng_pkg::*;
#(
    parameter logic [15:0] DEFAULT_SEED = RNG_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] state
);

    logic fb;

    assign fb = ^(state & RNG_TAPS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= DEFAULT_SEED;
        end else if (load) begin
            state <= (seed == 16'd0) ? DEFAULT_SEED : seed;
        end else if (step) begin
            state <= {fb, state[15:1]};
        end
    end

endmodule

// File: rtl/rng_share_ctrl.sv
// rng_share_ctrl: round-robin arbiter sharing one LFSR among NREQ
// requesters, with mask-and-reject range reduction and safe reseeding.
module rng_share_ctrl
    import rng_pkg::*;
#(
    parameter int          NREQ         = 4,
    parameter logic [15:0] DEFAULT_SEED = RNG_DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [15:0]          seed_i,
    input  logic                 seed_load_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [16*NREQ-1:0]   req_limit_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 rsp_valid_o,
    output logic [15:0]          rsp_data_o,
    output logic [2:0]           rsp_id_o,
    input  logic                 rsp_ready_i,
    output logic                 busy_o
);

    rng_state_t      state, state_n;
    logic [2:0]      rr_ptr;
    logic            reseed_pend;
    logic [15:0]     seed_q;
    logic [2:0]      id_q;
    logic [15:0]     limit_q;
    logic [15:0]     mask_q;
    logic [15:0]     lfsr;
    logic [15:0]     cand;
    logic            accept;
    logic            lfsr_load;
    logic            lfsr_step;
    logic            grant;
    logic            found;
    logic [2:0]      win_id;
    logic [15:0]     win_limit;
    logic [NREQ-1:0] win_oh;

    rng_lfsr16 #(
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rstn  (rstn),
        .load  (lfsr_load),
        .seed  (seed_q),
        .step  (lfsr_step),
        .state (lfsr)
    );

    // First pass covers rr_ptr..NREQ-1, second pass wraps from 0.
    always_comb begin
        found     = 1'b0;
        win_id    = '0;
        win_limit = '0;
        win_oh    = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req_valid_i[j] && (j >= int'(rr_ptr))) begin
                found     = 1'b1;
                win_id    = 3'(j);
                win_limit = req_limit_i[16*j +: 16];
                win_oh[j] = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req_valid_i[j]) begin
                found     = 1'b1;
                win_id    = 3'(j);
                win_limit = req_limit_i[16*j +: 16];
                win_oh[j] = 1'b1;
            end
        end
    end

    assign cand   = lfsr & mask_q;
    assign accept = (limit_q == 16'd0) || (cand < limit_q);

    always_comb begin
        state_n   = state;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        grant     = 1'b0;
        unique case (state)
            IDLE: begin
                if (reseed_pend) begin
                    lfsr_load = 1'b1;
                end else if (found) begin
                    grant   = 1'b1;
                    state_n = GEN;
                end
            end
            GEN: begin
                lfsr_step = 1'b1;
                if (accept) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign req_ready_o = grant ? win_oh : '0;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Latest strobe wins; the load itself waits for an IDLE cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reseed_pend <= 1'b0;
            seed_q      <= '0;
        end else if (seed_load_i) begin
            reseed_pend <= 1'b1;
            seed_q      <= seed_i;
        end else if (lfsr_load) begin
            reseed_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q    <= '0;
            limit_q <= '0;
            mask_q  <= '0;
        end else if (grant) begin
            id_q    <= win_id;
            limit_q <= win_limit;
            mask_q  <= mask_for_limit(win_limit);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_id_o    <= '0;
            rr_ptr      <= '0;
        end else if ((state == GEN) && accept) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= cand;
            rsp_id_o    <= id_q;
        end else if ((state == RESP) && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rr_ptr      <= (id_q == 3'(NREQ - 1)) ? 3'd0 : id_q + 3'd1;
        end
    end

endmodule

// File: tb/tb_rng_share_ctrl.sv
// tb_rng_share_ctrl: scoreboard bench for rng_share_ctrl with directed
// draws plus randomized traffic checked against a reference model.
module tb_rng_share_ctrl;

    localparam int          NREQ  = 4;
    localparam logic [15:0] SEED0 = 16'hACE1;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b1;
    logic [15:0]          seed_i = '0;
    logic                 seed_load = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [16*NREQ-1:0]   req_limit = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [15:0]          rsp_data;
    logic [2:0]           rsp_id;
    logic                 rsp_ready = 1'b0;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nrsp = 0;

    logic [18:0]     exp_q[$];
    logic [NREQ-1:0] gnt_seen = '0;

    rng_share_ctrl #(
        .NREQ         (NREQ),
        .DEFAULT_SEED (SEED0)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .seed_i      (seed_i),
        .seed_load_i (seed_load),
        .req_valid_i (req_valid),
        .req_limit_i (req_limit),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_id_o    (rsp_id),
        .rsp_ready_i (rsp_ready),
        .busy_o      (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Grow an all-ones mask until it covers every value below limit.
    function automatic logic [15:0] smask(input logic [15:0] lim);
        int m;
        int l;
        if (lim == 16'd0) return 16'hFFFF;
        m = 0;
        l = int'(lim);
        while (m < l - 1) m = 2 * m + 1;
        return 16'(m);
    endfunction

    function automatic logic [15:0] rand_lim();
        case ($urandom_range(5))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'($urandom_range(20, 2));
            3:       return 16'h00C0;
            4:       return 16'h0100;
            default: return 16'($urandom);
        endcase
    endfunction

    // Reference model: predicts winner and value at each grant.
    initial begin : mon_p
        logic [15:0] m_lfsr;
        int          m_rr;
        logic        m_pend;
        logic [15:0] m_seed;
        logic        hold_v;
        logic [18:0] hold_val;
        logic [18:0] e;
        logic [15:0] lim, msk, cand;
        int          w;
        m_lfsr = SEED0;
        m_rr = 0;
        m_pend = 1'b0;
        m_seed = '0;
        hold_v = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_q.delete();
                m_lfsr = SEED0;
                m_rr = 0;
                m_pend = 1'b0;
                hold_v = 1'b0;
            end else begin
                if (hold_v)
                    chk("rsp_hold", 32'({rsp_valid, rsp_id, rsp_data}),
                        32'({1'b1, hold_val}));
                hold_v = rsp_valid && !rsp_ready;
                hold_val = {rsp_id, rsp_data};
                if (rsp_valid && rsp_ready) begin
                    nrsp++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_rsp: got id %0d data %h expected none",
                                 rsp_id, rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", 32'(rsp_id), 32'(e[18:16]));
                        chk("rsp_data", 32'(rsp_data), 32'(e[15:0]));
                    end
                end
                if (req_ready != '0) begin
                    gnt_seen = gnt_seen | req_ready;
                    w = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        int j;
                        j = (m_rr + k) % NREQ;
                        if (w < 0 && req_valid[j]) w = j;
                    end
                    if (w < 0) begin
                        chk("grant_without_req", 32'(req_ready), 32'(0));
                    end else begin
                        chk("grant_onehot", 32'(req_ready), 32'(1) << w);
                        if (m_pend) begin
                            m_lfsr = (m_seed == 16'd0) ? SEED0 : m_seed;
                            m_pend = 1'b0;
                        end
                        lim = req_limit[16*w +: 16];
                        msk = smask(lim);
                        do begin
                            cand = m_lfsr & msk;
                            m_lfsr = lfsr_next(m_lfsr);
                        end while (!(lim == 16'd0 || cand < lim));
                        exp_q.push_back({3'(w), cand});
                        m_rr = (w + 1) % NREQ;
                    end
                end
                if (seed_load) begin
                    m_pend = 1'b1;
                    m_seed = seed_i;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        req_valid = '0;
        seed_load = 1'b0;
        rsp_ready = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data), 32'(0));
        chk("rst_rsp_id", 32'(rsp_id), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic wait_gnt(output logic [NREQ-1:0] g);
        int t;
        t = 0;
        @(negedge clk);
        while (req_ready == '0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("grant_timeout", 32'(t < 50), 32'(1));
        g = req_ready;
    endtask

    task automatic wait_rsp();
        int t;
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rsp_timeout", 32'(t < 50), 32'(1));
    endtask

    task automatic draw1(input int id, input logic [15:0] lim,
                         input logic [15:0] ev, input int el, input string nm);
        logic [NREQ-1:0] g;
        int c0;
        req_limit[16*id +: 16] = lim;
        req_valid[id] = 1'b1;
        rsp_ready = 1'b1;
        wait_gnt(g);
        c0 = cyc;
        chk({nm, "_grant"}, 32'(g), 32'(1) << id);
        @(posedge clk);
        #1;
        req_valid = req_valid & ~g;
        wait_rsp();
        chk({nm, "_latency"}, 32'(cyc - c0), 32'(el));
        chk({nm, "_data"}, 32'(rsp_data), 32'(ev));
        chk({nm, "_id"}, 32'(rsp_id), 32'(id));
        @(posedge clk);
        #1;
    endtask

    initial begin : stim_p
        logic [NREQ-1:0] g;
        int t;

        do_reset();
        draw1(0, 16'h0000, 16'hACE1, 2, "full0");
        draw1(0, 16'h0000, 16'h5670, 2, "full1");

        do_reset();
        draw1(0, 16'h0100, 16'h00E1, 2, "lim100");

        do_reset();
        draw1(0, 16'h00C0, 16'h0070, 3, "rejectC0");

        do_reset();
        for (int k = 0; k < NREQ; k++) req_limit[16*k +: 16] = 16'h0001;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            wait_gnt(g);
            chk("rr_grant", 32'(g), 32'(1) << k);
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
            wait_rsp();
            chk("rr_data", 32'(rsp_data), 32'(0));
            chk("rr_id", 32'(rsp_id), 32'(k));
        end
        @(posedge clk);
        #1;

        do_reset();
        draw1(0, 16'h0000, 16'hACE1, 2, "rs_first");
        req_limit[15:0] = 16'h0000;
        req_valid[0] = 1'b1;
        rsp_ready = 1'b0;
        wait_gnt(g);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_rsp();
        @(posedge clk);
        #1;
        seed_i = 16'h0000;
        seed_load = 1'b1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        seed_i = 16'h1234;
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("rs_hold_valid", 32'(rsp_valid), 32'(1));
        chk("rs_hold_data", 32'(rsp_data), 32'h5670);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rs_handshake", 32'(rsp_valid), 32'(1));
        @(negedge clk);
        chk("rs_no_grant", 32'(req_ready), 32'(0));
        chk("rs_idle", 32'(busy), 32'(0));
        @(negedge clk);
        chk("rs_grant", 32'(req_ready), 32'(1));
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_rsp();
        chk("rs_data", 32'(rsp_data), 32'(SEED0));
        @(posedge clk);
        #1;

        do_reset();
        req_limit[15:0] = 16'h0000;
        req_valid[0] = 1'b1;
        rsp_ready = 1'b1;
        wait_gnt(g);
        @(posedge clk);
        #1;
        chk("gen_busy", 32'(busy), 32'(1));
        rstn = 1'b0;
        req_valid = '0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < NREQ; k++) req_limit[16*k +: 16] = 16'h0000;
        req_valid = '1;
        draw1(0, 16'h0000, SEED0, 2, "post_rst");
        req_valid = '0;

        gnt_seen = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            req_valid = req_valid & ~gnt_seen;
            gnt_seen = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_limit[16*i +: 16] = rand_lim();
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            seed_load = ($urandom_range(63) == 0);
            seed_i = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
        end

        @(posedge clk);
        #1;
        req_valid = '0;
        seed_load = 1'b0;
        rsp_ready = 1'b1;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'(0));
        chk("drain_busy", 32'(busy), 32'(0));
        chk("rsp_count_ok", 32'(nrsp > 200), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
